// File: rtl/turn_signal_ctrl_if.sv
// turn_signal_ctrl_if: driver inputs, sequencer patterns and lamp/mode outputs of the turn-signal controller.
interface turn_signal_ctrl_if;
  logic       left_req;
  logic       right_req;
  logic       hazard;
  logic       brake;
  logic [2:0] seq_L;
  logic [2:0] seq_R;
  logic [1:0] dir;
  logic       seq_step;
  logic [2:0] lamp_L;
  logic [2:0] lamp_R;
  logic [1:0] mode;
  modport master (
    output left_req, right_req, hazard, brake, seq_L, seq_R,
    input  dir, seq_step, lamp_L, lamp_R, mode
  );
  modport slave (
    input  left_req, right_req, hazard, brake, seq_L, seq_R,
    output dir, seq_step, lamp_L, lamp_R, mode
  );
endinterface

// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: mode arbitration, step prescaler and lamp override merge for the turn-signal sequencer.
module turn_signal_ctrl #(
  parameter int TICK_DIV  = 12500000,
  parameter int CNT_W     = 24,
  parameter int MIN_STEPS = 6
) (
  input logic               clk,
  input logic               rst_n,
  turn_signal_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] HAZ   = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hold_q, hold_d;
  logic             step_q, step_d, haz_q, haz_d;
  logic [2:0]       lamp_l_q, lamp_l_d, lamp_r_q, lamp_r_d;
  logic             only_l, only_r, chg, tc;
  logic [2:0]       brk;
  always_comb begin
    only_l   = bus.left_req & ~bus.right_req;
    only_r   = bus.right_req & ~bus.left_req;
    mode_d   = bus.hazard ? HAZ
             : (mode_q == HAZ || mode_q == IDLE) ? (only_l ? LEFT : only_r ? RIGHT : IDLE)
             : (mode_q == LEFT) ? (only_r ? RIGHT : (!bus.left_req && hold_q == 4'd0) ? IDLE : LEFT)
             : (only_l ? LEFT : (!bus.right_req && hold_q == 4'd0) ? IDLE : RIGHT);
    chg      = mode_d != mode_q;
    tc       = cnt_q == CNT_W'(TICK_DIV - 1);
    // a mode change restarts the step period and suppresses a coincident strobe
    cnt_d    = (chg || tc) ? '0 : cnt_q + CNT_W'(1);
    step_d   = tc & ~chg;
    hold_d   = chg ? 4'(MIN_STEPS)
             : (step_q && mode_q[0] && hold_q != 4'd0) ? hold_q - 4'd1 : hold_q;
    haz_d    = (chg && mode_d == HAZ) ? 1'b1
             : (step_q && mode_q == HAZ) ? ~haz_q : haz_q;
    brk      = {3{bus.brake}};
    lamp_l_d = (mode_q == HAZ) ? {3{haz_q}} : (mode_q == LEFT)  ? bus.seq_L : brk;
    lamp_r_d = (mode_q == HAZ) ? {3{haz_q}} : (mode_q == RIGHT) ? bus.seq_R : brk;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= IDLE;
      cnt_q    <= '0;
      hold_q   <= 4'd0;
      step_q   <= 1'b0;
      haz_q    <= 1'b1;
      lamp_l_q <= 3'b000;
      lamp_r_q <= 3'b000;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      haz_q    <= haz_d;
      lamp_l_q <= lamp_l_d;
      lamp_r_q <= lamp_r_d;
    end
  end
  // LEFT (11) and RIGHT (01) share bit 0; dir mirrors them and is 00 otherwise
  assign bus.dir      = mode_q[0] ? mode_q : 2'b00;
  assign bus.mode     = mode_q;
  assign bus.seq_step = step_q;
  assign bus.lamp_L   = lamp_l_q;
  assign bus.lamp_R   = lamp_r_q;
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb_turn_signal_ctrl: directed and randomized checks of turn_signal_ctrl against an age-based reference model.
module tb_turn_signal_ctrl;
  localparam int TICK = 4;
  localparam int MINS = 3;
  localparam logic [1:0] M_IDLE = 2'b00, M_RIGHT = 2'b01, M_HAZ = 2'b10, M_LEFT = 2'b11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  turn_signal_ctrl_if bus();
  turn_signal_ctrl #(.TICK_DIV(TICK), .CNT_W(24), .MIN_STEPS(MINS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // model: mode, edges elapsed since last mode change/reset, and registered lamps
  logic [1:0] m_mode;
  int         age;
  logic [2:0] m_ll, m_lr;
  function automatic int consumed();
    return (age == 0) ? 0 : (age - 1) / TICK;
  endfunction
  function automatic int hold_left();
    return (MINS > consumed()) ? MINS - consumed() : 0;
  endfunction
  function automatic logic [10:0] exp_vec();
    logic st;
    logic [1:0] d;
    st = (age > 0) && (age % TICK == 0);
    d = (m_mode == M_LEFT) ? 2'b11 : (m_mode == M_RIGHT) ? 2'b01 : 2'b00;
    return {m_mode, d, st, m_ll, m_lr};
  endfunction
  function automatic logic [10:0] dut_vec();
    return {bus.mode, bus.dir, bus.seq_step, bus.lamp_L, bus.lamp_R};
  endfunction
  task automatic model_reset();
    m_mode = M_IDLE;
    age = 0;
    m_ll = 3'b000;
    m_lr = 3'b000;
  endtask
  task automatic model_edge();
    logic ol, orr, hp;
    logic [1:0] nm;
    logic [2:0] brk;
    ol = bus.left_req & ~bus.right_req;
    orr = bus.right_req & ~bus.left_req;
    if (bus.hazard) nm = M_HAZ;
    else if (m_mode == M_IDLE || m_mode == M_HAZ) nm = ol ? M_LEFT : orr ? M_RIGHT : M_IDLE;
    else if (m_mode == M_LEFT) nm = orr ? M_RIGHT : (!bus.left_req && hold_left() == 0) ? M_IDLE : M_LEFT;
    else nm = ol ? M_LEFT : (!bus.right_req && hold_left() == 0) ? M_IDLE : M_RIGHT;
    hp = (consumed() % 2) == 0;
    brk = bus.brake ? 3'b111 : 3'b000;
    m_ll = (m_mode == M_HAZ) ? {3{hp}} : (m_mode == M_LEFT) ? bus.seq_L : brk;
    m_lr = (m_mode == M_HAZ) ? {3{hp}} : (m_mode == M_RIGHT) ? bus.seq_R : brk;
    age = (nm != m_mode) ? 0 : age + 1;
    m_mode = nm;
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_in(input logic l, input logic r, input logic h, input logic b);
    bus.left_req = l;
    bus.right_req = r;
    bus.hazard = h;
    bus.brake = b;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 0, 0, 1);
    bus.seq_L = 3'b101;
    bus.seq_R = 3'b010;
    model_reset();
    repeat (3) @(negedge clk);
    vecs++;
    if (dut_vec() !== 11'b0) begin
      errs++;
      $display("FAIL reset_values got %b exp %b", dut_vec(), 11'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL reset_release cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        vecs++;
        if (bus.mode !== 2'b11 || bus.dir !== 2'b11) begin
          errs++;
          $display("FAIL left_entry got mode %b dir %b exp 11 11", bus.mode, bus.dir);
        end
      end
    end
  endtask
  task automatic test_hold();
    int steps;
    steps = 0;
    do_reset();
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (i == 2) bus.left_req = 1'b0;
      bus.seq_L = 3'($urandom_range(0, 7));
      tick();
      if (bus.mode === M_LEFT && bus.seq_step === 1'b1) steps++;
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL hold cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
    vecs++;
    if (steps != MINS || bus.mode !== M_IDLE) begin
      errs++;
      $display("FAIL hold_steps got %0d steps mode %b exp %0d steps mode 00", steps, bus.mode, MINS);
    end
  endtask
  task automatic test_override();
    int n;
    n = 0;
    do_reset();
    set_in(1, 0, 0, 0);
    tick();
    while (!(m_mode == M_LEFT && hold_left() == 2) && n < 40) begin
      tick();
      n++;
    end
    vecs++;
    if (n >= 40) begin
      errs++;
      $display("FAIL override_setup got timeout exp hold 2");
    end
    set_in(0, 1, 0, 0);
    tick();
    vecs++;
    if (dut_vec() !== exp_vec() || bus.mode !== 2'b01 || bus.dir !== 2'b01) begin
      errs++;
      $display("FAIL override got %b exp %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL override_run cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_hazard();
    do_reset();
    set_in(0, 1, 0, 1);
    repeat (3) tick();
    bus.hazard = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.seq_L = 3'($urandom_range(0, 7));
      bus.seq_R = 3'($urandom_range(0, 7));
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL hazard cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
      if (i == 1) begin
        vecs++;
        if (bus.lamp_L !== 3'b111 || bus.lamp_R !== 3'b111 || bus.mode !== 2'b10) begin
          errs++;
          $display("FAIL hazard_entry got %b/%b mode %b exp 111/111 mode 10", bus.lamp_L, bus.lamp_R, bus.mode);
        end
      end
    end
    bus.hazard = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL hazard_exit cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
    vecs++;
    if (bus.mode !== 2'b01) begin
      errs++;
      $display("FAIL hazard_to_right got %b exp 01", bus.mode);
    end
  endtask
  task automatic test_both();
    do_reset();
    set_in(1, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL both cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
    vecs++;
    if (bus.mode !== 2'b00 || bus.lamp_L !== 3'b111 || bus.lamp_R !== 3'b111) begin
      errs++;
      $display("FAIL both_brake got mode %b %b/%b exp 00 111/111", bus.mode, bus.lamp_L, bus.lamp_R);
    end
  endtask
  task automatic test_seq_follow();
    logic [2:0] pat [3];
    pat = '{3'b001, 3'b011, 3'b111};
    do_reset();
    set_in(1, 0, 0, 1);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.seq_L = pat[i];
      tick();
      vecs++;
      if (dut_vec() !== exp_vec() || bus.lamp_R !== 3'b111 || bus.lamp_L !== pat[(i < 3) ? i : 2]) begin
        errs++;
        $display("FAIL seq_follow cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.left_req = ~bus.left_req;
      if ($urandom_range(0, 7) == 0) bus.right_req = ~bus.right_req;
      if ($urandom_range(0, 15) == 0) bus.hazard = ~bus.hazard;
      if ($urandom_range(0, 3) == 0) bus.brake = ~bus.brake;
      bus.seq_L = 3'($urandom_range(0, 7));
      bus.seq_R = 3'($urandom_range(0, 7));
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vecs++;
        if (dut_vec() !== 11'b0) begin
          errs++;
          $display("FAIL async_reset got %b exp %b", dut_vec(), 11'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL random cyc%0d got %b exp %b", i, dut_vec(), exp_vec());
      end
    end
  endtask
  initial begin
    set_in(0, 0, 0, 0);
    bus.seq_L = 3'b000;
    bus.seq_R = 3'b000;
    test_reset();
    test_hold();
    test_override();
    test_hazard();
    test_both();
    test_seq_follow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
